// File: rtl/modport_bridge.sv
// modport_bridge: AHB-Lite slave to APB master bridge.
//
// Every sampled AHB beat (single or burst, NONSEQ or SEQ) becomes one APB
// SETUP/ENABLE transfer to one of four slaves in the 0x8000_0000-0x8FFF_FFFF
// window. The slave index is Haddr[27:26]. The master is held off through
// Hreadyout until the APB transfer for its beat reaches ENABLE.
//
// Optional feature: define MODPORT_BRIDGE_ERR_EN to answer active beats that
// fall outside the mapped window with a two-cycle AHB ERROR response. Without
// it those beats are dropped silently and Hresp stays OKAY.
module modport_bridge (
    input  logic        clk,
    input  logic        Hrstn,
    input  logic        Hwrite,
    input  logic [2:0]  Hsize,
    input  logic [1:0]  Htrans,
    input  logic        Hreadyin,
    input  logic [31:0] Haddr,
    input  logic [2:0]  Hburst,
    input  logic [31:0] Hwdata,
    output logic [31:0] Hrdata,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    input  logic [31:0] Prdata,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Pwrite,
    output logic [3:0]  Pselx,
    output logic        Penable
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WWAIT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ENABLE = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    state_t      state;
    logic [31:0] addr_q;
    logic [3:0]  sel_q;
    logic [31:0] rdata_q;

    logic        beat_active;
    logic        addr_mapped;
    logic        beat_valid;
    logic [3:0]  decoded_sel;

    // Transfer size, burst type and the SEQ/NONSEQ distinction do not change
    // how a beat is converted, so these inputs are deliberately left unused.
    logic unused_inputs;
    assign unused_inputs = ^{Hsize, Hburst, Htrans[0]};

    // A beat is live when the bus is ready and the transfer is NONSEQ or SEQ.
    assign beat_active = Hreadyin & Htrans[1];
    assign addr_mapped = (Haddr[31:28] == 4'h8);
    assign beat_valid  = beat_active & addr_mapped;

    // Slave select decode: one APB slave per 64 MB quarter of the window.
    always_comb begin
        decoded_sel = 4'b0000;
        case (Haddr[27:26])
            2'b00:   decoded_sel = 4'b0001;
            2'b01:   decoded_sel = 4'b0010;
            2'b10:   decoded_sel = 4'b0100;
            default: decoded_sel = 4'b1000;
        endcase
    end

`ifdef MODPORT_BRIDGE_ERR_EN
    logic       beat_unmapped;
    logic [1:0] resp_q;

    assign beat_unmapped = beat_active & ~addr_mapped;
    assign Hresp         = resp_q;
`else
    assign Hresp = RESP_OKAY;
`endif

    // Read data follows the APB slave during a read ENABLE so the master can
    // sample it at the end of that cycle; otherwise the last read is held.
    assign Hrdata = (state == ST_ENABLE && !Pwrite) ? Prdata : rdata_q;

    // Bridge FSM: new beats are only accepted while Hreadyout is high (IDLE
    // or ENABLE), which is what lets bursts run back-to-back without gaps.
    always_ff @(posedge clk) begin
        if (Hrstn) begin
            state     <= ST_IDLE;
            addr_q    <= 32'h0;
            sel_q     <= 4'b0000;
            rdata_q   <= 32'h0;
            Paddr     <= 32'h0;
            Pwdata    <= 32'h0;
            Pwrite    <= 1'b0;
            Pselx     <= 4'b0000;
            Penable   <= 1'b0;
            Hreadyout <= 1'b1;
`ifdef MODPORT_BRIDGE_ERR_EN
            resp_q    <= RESP_OKAY;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_ENABLE: begin
                    Pselx     <= 4'b0000;
                    Penable   <= 1'b0;
                    Hreadyout <= 1'b1;
`ifdef MODPORT_BRIDGE_ERR_EN
                    resp_q    <= RESP_OKAY;
`endif
                    if (state == ST_ENABLE && !Pwrite) begin
                        rdata_q <= Prdata;
                    end
                    if (beat_valid) begin
                        addr_q    <= Haddr;
                        sel_q     <= decoded_sel;
                        Hreadyout <= 1'b0;
                        if (Hwrite) begin
                            state <= ST_WWAIT;
                        end else begin
                            state  <= ST_SETUP;
                            Pselx  <= decoded_sel;
                            Paddr  <= Haddr;
                            Pwrite <= 1'b0;
                        end
`ifdef MODPORT_BRIDGE_ERR_EN
                    end else if (beat_unmapped) begin
                        state     <= ST_ERR1;
                        resp_q    <= RESP_ERROR;
                        Hreadyout <= 1'b0;
`endif
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_WWAIT: begin
                    state  <= ST_SETUP;
                    Pwdata <= Hwdata;
                    Paddr  <= addr_q;
                    Pwrite <= 1'b1;
                    Pselx  <= sel_q;
                end

                ST_SETUP: begin
                    state     <= ST_ENABLE;
                    Penable   <= 1'b1;
                    Hreadyout <= 1'b1;
                end

`ifdef MODPORT_BRIDGE_ERR_EN
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    Hreadyout <= 1'b1;
                end

                ST_ERR2: begin
                    state     <= ST_IDLE;
                    resp_q    <= RESP_OKAY;
                    Hreadyout <= 1'b1;
                end
`endif

                default: begin
                    state     <= ST_IDLE;
                    Pselx     <= 4'b0000;
                    Penable   <= 1'b0;
                    Hreadyout <= 1'b1;
                end
            endcase
        end
    end

    // APB protocol sanity: at most one slave selected, enable never repeats.
    a_sel_onehot0: assert property (@(posedge clk) disable iff (Hrstn)
        $onehot0(Pselx));
    a_enable_single: assert property (@(posedge clk) disable iff (Hrstn)
        !(Penable && $past(Penable)));

endmodule

// File: tb/tb_modport_bridge.sv
// tb_modport_bridge: randomized scoreboard bench for modport_bridge.
// The driver issues AHB beats and queues the APB transfer each one should
// produce; an independent monitor pops and compares on every APB ENABLE.
module tb_modport_bridge;

    logic        clk = 1'b0;
    logic        Hrstn;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [1:0]  Htrans;
    logic        Hreadyin;
    logic [31:0] Haddr;
    logic [2:0]  Hburst;
    logic [31:0] Hwdata;
    logic [31:0] Hrdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Prdata;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Pwrite;
    logic [3:0]  Pselx;
    logic        Penable;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } xfer_t;

    xfer_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd = 32'h0;
    logic        use_fixed = 1'b0;
    logic [31:0] fixed_prdata = 32'h0;

    always #5 clk = ~clk;

    modport_bridge dut (
        .clk       (clk),
        .Hrstn     (Hrstn),
        .Hwrite    (Hwrite),
        .Hsize     (Hsize),
        .Htrans    (Htrans),
        .Hreadyin  (Hreadyin),
        .Haddr     (Haddr),
        .Hburst    (Hburst),
        .Hwdata    (Hwdata),
        .Hrdata    (Hrdata),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Prdata    (Prdata),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Pwrite    (Pwrite),
        .Pselx     (Pselx),
        .Penable   (Penable)
    );

    function automatic bit is_mapped(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a <= 32'h8FFF_FFFF);
    endfunction

    // Each slave owns one 64 MB quarter of the window.
    function automatic logic [3:0] slave_of(input logic [31:0] a);
        logic [3:0] s;
        s = 4'b0001 << ((a - 32'h8000_0000) / 32'h0400_0000);
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reset with random bus activity, then confirm every output is at rest.
    task automatic doReset();
        Hrstn = 1'b1;
        repeat (2) begin
            Haddr    = $urandom;
            Htrans   = 2'($urandom);
            Hwrite   = 1'($urandom);
            Hreadyin = 1'($urandom);
            Hwdata   = $urandom;
            Hsize    = 3'($urandom);
            Hburst   = 3'($urandom);
            step();
        end
        exp_q.delete();
        last_rd = 32'h0;
        checkOutput("reset_hreadyout", 32'(Hreadyout), 32'd1);
        checkOutput("reset_pselx", 32'(Pselx), 32'd0);
        checkOutput("reset_penable", 32'(Penable), 32'd0);
        checkOutput("reset_hresp", 32'(Hresp), 32'd0);
        checkOutput("reset_hrdata", Hrdata, 32'd0);
        checkOutput("reset_paddr", Paddr, 32'd0);
        checkOutput("reset_pwdata", Pwdata, 32'd0);
        Htrans   = 2'b00;
        Hreadyin = 1'b1;
        Hrstn    = 1'b0;
    endtask

    // Present one address phase in a cycle where Hreadyout is high, supply
    // write data in the following cycle, and wait for the beat to complete.
    // Returns in the completing cycle so a following beat lands back-to-back.
    task automatic applyStimulus(input logic [31:0] addr, input logic wr,
                                 input logic [1:0] trans, input logic rdy,
                                 input logic [31:0] wdata);
        bit    active;
        bit    err_beat;
        int    exp_cycles;
        int    cycles;
        xfer_t e;
        active     = rdy && trans[1];
        err_beat   = 1'b0;
        exp_cycles = 1;
        Haddr    = addr;
        Hwrite   = wr;
        Htrans   = trans;
        Hreadyin = rdy;
        Hsize    = 3'd2;
        Hburst   = 3'($urandom);
        if (active && is_mapped(addr)) begin
            e.addr  = addr;
            e.wr    = wr;
            e.wdata = wdata;
            e.sel   = slave_of(addr);
            exp_q.push_back(e);
            exp_cycles = wr ? 3 : 2;
        end else if (active) begin
`ifdef MODPORT_BRIDGE_ERR_EN
            exp_cycles = 2;
            err_beat   = 1'b1;
`endif
        end
        step();
        Htrans   = 2'b00;
        Hreadyin = 1'b1;
        Haddr    = $urandom;
        Hwdata   = wdata;
        cycles   = 1;
        if (err_beat) begin
            checkOutput("hresp_err_first", 32'(Hresp), 32'd1);
        end
        while (!Hreadyout && cycles < 16) begin
            step();
            cycles++;
        end
        checkOutput("hready_latency", 32'(cycles), 32'(exp_cycles));
        checkOutput("hresp_final", 32'(Hresp), err_beat ? 32'd1 : 32'd0);
        if (err_beat) begin
            step();
        end
    endtask

    // Random APB read data, changed well away from both clock edges.
    initial begin
        Prdata = 32'h0;
        forever begin
            @(posedge clk);
            #3;
            Prdata = use_fixed ? fixed_prdata : $urandom;
        end
    end

    // Monitor: every ENABLE cycle retires the oldest expected transfer.
    initial begin : monitor
        xfer_t       e;
        logic        prev_pen;
        logic [3:0]  prev_sel;
        logic [31:0] prev_paddr;
        prev_pen   = 1'b0;
        prev_sel   = 4'b0;
        prev_paddr = 32'h0;
        forever begin
            @(negedge clk);
            if (!Hrstn) begin
                if (Penable) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_apb actual=%h required=none", Paddr);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("paddr", Paddr, e.addr);
                        checkOutput("pselx", 32'(Pselx), 32'(e.sel));
                        checkOutput("pwrite", 32'(Pwrite), 32'(e.wr));
                        checkOutput("setup_phase", {prev_pen, prev_sel, prev_paddr[26:0]},
                                    {1'b0, e.sel, e.addr[26:0]});
                        if (e.wr) begin
                            checkOutput("pwdata", Pwdata, e.wdata);
                            checkOutput("hrdata_hold", Hrdata, last_rd);
                        end else begin
                            checkOutput("hrdata_enable", Hrdata, Prdata);
                            last_rd = Prdata;
                        end
                    end
                end else begin
                    checkOutput("hrdata_hold", Hrdata, last_rd);
                    checkOutput("pselx_onehot0", 32'($onehot0(Pselx)), 32'd1);
                end
            end
            prev_pen   = Penable;
            prev_sel   = Pselx;
            prev_paddr = Paddr;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        logic [31:0] addr;
        logic [1:0]  trans;
        Hrstn    = 1'b1;
        Hwrite   = 1'b0;
        Hsize    = 3'd2;
        Htrans   = 2'b00;
        Hreadyin = 1'b1;
        Haddr    = 32'h0;
        Hburst   = 3'd0;
        Hwdata   = 32'h0;
        step();
        doReset();
        $display("[TB] directed single write / read");
        applyStimulus(32'h8000_0010, 1'b1, 2'b10, 1'b1, 32'hDEAD_BEEF);
        fixed_prdata = 32'h1234_5678;
        use_fixed    = 1'b1;
        applyStimulus(32'h8800_0004, 1'b0, 2'b10, 1'b1, 32'h0);
        checkOutput("single_read_hrdata", Hrdata, 32'h1234_5678);
        use_fixed = 1'b0;

        $display("[TB] INCR4 read burst and write burst");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h8C00_0000 + 32'(4 * i), 1'b0,
                          (i == 0) ? 2'b10 : 2'b11, 1'b1, $urandom);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h8400_0100 + 32'(4 * i), 1'b1,
                          (i == 0) ? 2'b10 : 2'b11, 1'b1, $urandom);
        end

        $display("[TB] ignored beats and unmapped address");
        applyStimulus(32'h8000_0020, 1'b0, 2'b00, 1'b1, 32'h0);
        applyStimulus(32'h8000_0024, 1'b1, 2'b01, 1'b1, 32'h0);
        applyStimulus(32'h8000_0028, 1'b0, 2'b10, 1'b0, 32'h0);
        applyStimulus(32'h1000_0000, 1'b0, 2'b10, 1'b1, 32'h0);
        applyStimulus(32'h1000_0000, 1'b1, 2'b10, 1'b1, 32'h0);
        applyStimulus(32'h8000_0030, 1'b0, 2'b10, 1'b1, 32'h0);

        $display("[TB] randomized beats");
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                addr = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
            end else begin
                addr = $urandom;
                if (addr[31:28] == 4'h8) addr[31:28] = 4'h9;
            end
            if ($urandom_range(0, 3) != 0) trans = 2'($urandom_range(2, 3));
            else                           trans = 2'($urandom_range(0, 1));
            applyStimulus(addr, 1'($urandom_range(0, 1)), trans,
                          ($urandom_range(0, 7) != 0), $urandom);
            if ($urandom_range(0, 4) == 0) begin
                Htrans = 2'b00;
                step();
            end
        end

        $display("[TB] reset in the middle of a write");
        Htrans = 2'b00;
        repeat (3) step();
        Haddr    = 32'h8800_0040;
        Hwrite   = 1'b1;
        Htrans   = 2'b10;
        Hreadyin = 1'b1;
        step();
        Htrans = 2'b00;
        Hwdata = $urandom;
        step();
        checkOutput("midreset_setup_sel", 32'(Pselx), 32'(slave_of(32'h8800_0040)));
        checkOutput("midreset_setup_penable", 32'(Penable), 32'd0);
        Hrstn = 1'b1;
        step();
        checkOutput("midreset_pselx", 32'(Pselx), 32'd0);
        checkOutput("midreset_penable", 32'(Penable), 32'd0);
        doReset();
        applyStimulus(32'h8400_0008, 1'b0, 2'b10, 1'b1, 32'h0);

        Htrans = 2'b00;
        repeat (4) step();
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modport_bridge.md
# modport_bridge

AHB-Lite slave to APB master bridge: accepts AHB single and burst transfers and converts each beat into one APB SETUP/ENABLE transfer to one of four APB slaves. Sits between the AHB master and the APB peripheral bus. Every AHB beat stalls the master via `Hreadyout` until its APB transfer completes. `Hresp` is OKAY unless the error option is compiled in.

## Interface
Parameters:
- none

Ports:
- `clk` in 1 — single clock, rising edge.
- `Hrstn` in 1 — synchronous, active-high reset; asserted = 1.
- `Hwrite` in 1 — 1 = write, 0 = read.
- `Hsize` in 3 — accepted, ignored; all transfers are 32-bit.
- `Htrans` in 2 — IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `Hreadyin` in 1 — bus ready; a beat is sampled only when it is 1.
- `Haddr` in 32 — byte address.
- `Hburst` in 3 — accepted, ignored; each beat is converted independently.
- `Hwdata` in 32 — write data, valid one cycle after the address phase.
- `Hrdata` out 32 — read data.
- `Hreadyout` out 1 — 0 stalls the master.
- `Hresp` out 2 — 00 OKAY, 01 ERROR.
- `Prdata` in 32 — APB read data.
- `Paddr` out 32 — APB address.
- `Pwdata` out 32 — APB write data.
- `Pwrite` out 1 — APB direction.
- `Pselx` out 4 — one-hot slave select.
- `Penable` out 1 — APB enable.

## Operation
- Valid beat: `Hreadyin`=1, `Htrans` is NONSEQ or SEQ, and `Haddr` is in 0x8000_0000–0x8FFF_FFFF.
- IDLE and BUSY beats, and beats while `Hreadyin`=0, are ignored with an OKAY response.
- Slave decode uses `Haddr[27:26]`: 00→0001, 01→0010, 10→0100, 11→1000.
- Addresses outside the mapped window produce `Pselx`=0000 and never start an APB transfer.
- On a valid beat the bridge registers `Haddr`, `Hwrite` and the decoded select.
- States:
  - IDLE → SETUP on a read, WWAIT on a write.
  - WWAIT: captures `Hwdata` → SETUP.
  - SETUP → ENABLE.
  - ENABLE → IDLE, or SETUP/WWAIT when a new valid beat is sampled in ENABLE (back-to-back).
- SETUP outputs: `Pselx` = decoded select, `Paddr`, `Pwrite`, `Pwdata` (writes only), `Penable`=0.
- ENABLE outputs: same as SETUP with `Penable`=1.
- Outside SETUP and ENABLE: `Pselx`=0000, `Penable`=0.
- `Penable` is high for exactly one cycle per transfer.
- `Pselx` is always one-hot or zero.
- `Hrdata` = `Prdata` during ENABLE of a read, held until the next read's ENABLE. `Hrdata` is 0 after reset.
- SEQ beats of any burst are handled exactly like NONSEQ beats.

## Timing
- Reset values:
  - `Hreadyout`=1, `Hresp`=00.
  - All other outputs 0.
  - State = IDLE.
- Reset has priority over every transition. Asserting it mid-transfer clears `Penable`/`Pselx` at the next edge; the interrupted APB transfer is abandoned.
- Read beat, address sampled at edge N:
  - SETUP in cycle N+1, ENABLE in cycle N+2.
  - `Hreadyout`=0 in cycle N+1 and 1 in cycle N+2.
  - The master samples `Hrdata` at the end of N+2.
- Write beat, address sampled at edge N:
  - WWAIT in cycle N+1 (`Hwdata` captured at edge N+1).
  - SETUP in N+2, ENABLE in N+3.
  - `Hreadyout`=0 in N+1 and N+2, 1 in N+3.
- `Hreadyout` is 0 in WWAIT and SETUP, 1 in IDLE and ENABLE.
- Burst throughput:
  - Reads: 2 cycles per beat.
  - Writes: 3 cycles per beat.

## Configuration
- `MODPORT_BRIDGE_ERR_EN` defined:
  - A NONSEQ/SEQ beat with `Hreadyin`=1 to an unmapped address gets a two-cycle ERROR response.
  - Cycle 1: `Hresp`=01, `Hreadyout`=0.
  - Cycle 2: `Hresp`=01, `Hreadyout`=1.
  - Then IDLE; no APB activity.
- `MODPORT_BRIDGE_ERR_EN` undefined:
  - Unmapped beats are ignored silently.
  - `Hresp` is tied to 00.

## Test plan
- Reset: hold `Hrstn`=1 for 2 cycles with random inputs → `Hreadyout`=1, `Pselx`=0, `Penable`=0, `Hresp`=00.
- Single write:
  - Stimulus: `Haddr`=0x8000_0010, `Hwrite`=1, NONSEQ, then `Hwdata`=0xDEAD_BEEF.
  - Response: SETUP at N+2 with `Pselx`=0001, `Paddr`=0x8000_0010, `Pwdata`=0xDEAD_BEEF, `Pwrite`=1; `Penable`=1 only at N+3; `Hreadyout` goes 0,0,1.
- Single read:
  - Stimulus: `Haddr`=0x8800_0004, `Prdata`=0x1234_5678.
  - Response: `Pselx`=0100, `Penable` high only at N+2, `Hrdata`=0x1234_5678 with `Hreadyout`=1 at N+2.
- INCR4 read burst:
  - Stimulus: 0x8C00_0000 NONSEQ then three SEQ beats.
  - Response: four SETUP/ENABLE pairs on `Pselx`=1000, addresses +0/+4/+8/+C, `Penable` never high two cycles in a row.
- IDLE/BUSY and `Hreadyin`=0 beats → no `Pselx` activity, `Hreadyout` stays 1.
- Unmapped `Haddr`=0x1000_0000 NONSEQ → no APB activity. With `MODPORT_BRIDGE_ERR_EN` defined, the two-cycle `Hresp`=01 sequence appears.
